// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared state type and constants for the host-to-APB bridge
package apb_bridge_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int APB_ADDR_W = 16;
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/apb_bridge_top.sv
// apb_bridge_top: single-outstanding host request to APB master bridge
// Ports: sys_clk/rst (async active-high); host_valid/ready/addr/wdata/wstrb/rdata
//   host side (wstrb != 0 means write); apb_* APB master side.
// Optional: APB_BRIDGE_TIMEOUT_EN forces completion after TIMEOUT_CYCLES ACCESS cycles.
module apb_bridge_top
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [31:0]       host_addr,
  input  logic [31:0]       host_wdata,
  input  logic [3:0]        host_wstrb,
  output logic [31:0]       host_rdata,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic              apb_pwrite,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic [3:0]        apb_pstrb,
  output logic [31:0]       apb_pwdata,
  input  logic [31:0]       apb_prdata,
  input  logic              apb_pready,
  input  logic              apb_pslverr
);
  state_t state;
  logic expired;
  logic unused;
  assign unused = &{1'b0, host_addr[31:ADDR_W]};
`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // counts ACCESS cycles without pready; cleared everywhere else
  assign expired = !apb_pready && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == ACCESS && !apb_pready) ? cnt + 1'b1 : '0;
`else
  logic unused_to;
  assign unused_to = TIMEOUT_CYCLES > 0;
  assign expired = 1'b0;
`endif
  assign host_ready = state == RESP;
  assign apb_psel = state == SETUP || state == ACCESS;
  assign apb_penable = state == ACCESS;
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      host_rdata <= '0;
      apb_paddr <= '0;
      apb_pwrite <= 1'b0;
      apb_pwdata <= '0;
      apb_pstrb <= '0;
    end else begin
      case (state)
        IDLE: if (host_valid) begin
          state <= SETUP;
          apb_paddr <= host_addr[ADDR_W-1:0];
          apb_pwrite <= |host_wstrb;
          apb_pwdata <= host_wdata;
          apb_pstrb <= host_wstrb;
        end
        SETUP: state <= ACCESS;
        ACCESS: if (apb_pready || expired) begin
          state <= RESP;
          // a timed-out read has no valid prdata, so it reports the error pattern
          if (!apb_pwrite) host_rdata <= (apb_pslverr || !apb_pready) ? ERR_RDATA : apb_prdata;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_bridge_top.sv
// tb_apb_bridge_top: randomized and directed check of apb_bridge_top against a transaction-level model
module tb_apb_bridge_top;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic host_valid = 1'b0;
  logic host_ready;
  logic [31:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [3:0] host_wstrb = '0;
  logic [31:0] host_rdata;
  logic [15:0] apb_paddr;
  logic apb_pwrite, apb_psel, apb_penable;
  logic [3:0] apb_pstrb;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata = '0;
  logic apb_pready = 1'b0;
  logic apb_pslverr = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] exp_rdata = '0;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;
`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int TO = 256;
`else
  localparam int TO = 1 << 30;
`endif

  apb_bridge_top dut (
    .sys_clk(sys_clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_wstrb(host_wstrb),
    .host_rdata(host_rdata), .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pstrb(apb_pstrb),
    .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata), .apb_pready(apb_pready),
    .apb_pslverr(apb_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One host transaction with an in-bench slave that inserts `waits` wait states
  // and returns {16'h0, paddr} on reads.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int waits, input bit err, input bit hold);
    bit to_hit, done;
    int lat, acc, setups;
    to_hit = waits >= TO;
    lat = to_hit ? 2 + TO : 3 + waits;
    host_addr = a; host_wdata = d; host_wstrb = s; host_valid = 1'b1;
    acc = 0; setups = 0; done = 0;
    for (int cyc = 1; cyc <= lat + 3 && !done; cyc++) begin
      @(posedge sys_clk); #1;
      if (apb_psel && !apb_penable) begin
        setups++;
        chk("setup_paddr", 32'(apb_paddr), {16'h0, a[15:0]});
        chk("setup_pwrite", 32'(apb_pwrite), 32'(s != 4'h0));
        chk("setup_pwdata", apb_pwdata, d);
        chk("setup_pstrb", 32'(apb_pstrb), 32'(s));
        host_addr = $urandom; host_wdata = $urandom;
      end else if (apb_psel && apb_penable) begin
        acc++;
        if (acc == 1 || acc == waits + 1) begin
          chk("access_paddr", 32'(apb_paddr), {16'h0, a[15:0]});
          chk("access_pwdata", apb_pwdata, d);
        end
        apb_pready = acc > waits;
        apb_prdata = {16'h0, apb_paddr};
        apb_pslverr = err;
      end else if (host_ready) begin
        done = 1;
        chk("latency", 32'(cyc), 32'(lat));
        chk("resp_psel", {apb_psel, apb_penable}, 2'b00);
        apb_pready = 1'b0; apb_pslverr = 1'b0;
        if (s == 4'h0) exp_rdata = (err || to_hit) ? ERR : {16'h0, a[15:0]};
        chk("rdata", host_rdata, exp_rdata);
        if (!hold) host_valid = 1'b0;
      end
    end
    chk("ready_seen", 32'(done), 32'd1);
    if (hold) begin
      @(posedge sys_clk); #1;
      chk("no_reissue_psel", 32'(apb_psel), 32'd0);
      chk("no_second_ready", 32'(host_ready), 32'd0);
      host_valid = 1'b0;
    end
    @(posedge sys_clk); #1;
    chk("idle_psel", 32'(apb_psel), 32'd0);
    chk("idle_ready", 32'(host_ready), 32'd0);
    chk("rdata_hold", host_rdata, exp_rdata);
    chk("single_transfer", 32'(setups), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_ready", 32'(host_ready), 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk("rst_psel", {apb_psel, apb_penable, apb_pwrite}, 3'b000);
    chk("rst_paddr", 32'(apb_paddr), 32'd0);
    chk("rst_pwdata", apb_pwdata, 32'd0);
    chk("rst_pstrb", 32'(apb_pstrb), 32'd0);
    @(negedge sys_clk); rst = 1'b0;
    xfer(32'h1000_4000, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
    xfer(32'h1000_4000, 32'h0, 4'h0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      xfer(32'h1000_5000 + 4 * i, 32'hA000_0000 + i, 4'hF, 0, 0, 1);
      xfer(32'h1000_5000 + 4 * i, 32'h0, 4'h0, 0, 0, 1);
    end
    xfer(32'h1000_6000, 32'h0, 4'h0, 2, 1, 0);
    xfer(32'h1000_6004, 32'h1234_5678, 4'h3, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] s;
      s = ($urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
      xfer($urandom, $urandom, s, int'($urandom_range(3)), bit'($urandom_range(1)), bit'($urandom_range(1)));
    end
    host_addr = 32'h2000_7000; host_wstrb = 4'h0; host_valid = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("pre_rst_access", {apb_psel, apb_penable}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("midrst_psel", {apb_psel, apb_penable}, 2'b00);
    chk("midrst_ready", 32'(host_ready), 32'd0);
    chk("midrst_rdata", host_rdata, 32'd0);
    exp_rdata = '0;
    @(negedge sys_clk); rst = 1'b0;
    xfer(32'h2000_7000, 32'h0, 4'h0, 1, 0, 0);
`ifdef APB_BRIDGE_TIMEOUT_EN
    xfer(32'h3000_0010, 32'h0, 4'h0, 100000, 0, 0);
    xfer(32'h3000_0014, 32'h5555_AAAA, 4'hF, 100000, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_bridge_top.md
APB_BRIDGE_TOP -- requirements
Module: apb_bridge_top

Interface
REQ-001 Parameter: ADDR_W, 16, APB address width; equals host_addr[ADDR_W-1:0].
REQ-002 Parameter: TIMEOUT_CYCLES, 256, max ACCESS cycles before forced completion (only with APB_BRIDGE_TIMEOUT_EN).
REQ-003 Port: sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: host_valid  in  1  host request pending; held until host_ready seen.
REQ-006 Port: host_ready  out  1  one-cycle completion pulse.
REQ-007 Port: host_addr  in  32  byte address; bits [31:ADDR_W] ignored (decoded upstream).
REQ-008 Port: host_wdata  in  32  write data.
REQ-009 Port: host_wstrb  in  4  byte strobes; nonzero = write, zero = read.
REQ-010 Port: host_rdata  out  32  registered read data.
REQ-011 Port: apb_paddr  out  ADDR_W  APB address.
REQ-012 Port: apb_pwrite, apb_psel, apb_penable  out  1 each  APB control.
REQ-013 Port: apb_pstrb  out  4;  apb_pwdata  out  32.
REQ-014 Port: apb_prdata  in  32;  apb_pready  in  1;  apb_pslverr  in  1.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS, RESP; one transfer outstanding at a time.
REQ-016 IDLE: on host_valid=1, register paddr=host_addr[ADDR_W-1:0], pwrite=|host_wstrb, pwdata=host_wdata, pstrb=host_wstrb (4'h0 for reads); go to SETUP.
REQ-017 SETUP: psel=1, penable=0 for exactly one cycle; go to ACCESS.
REQ-018 ACCESS: psel=1, penable=1; wait states allowed; when pready=1, go to RESP; read captures prdata into host_rdata on that edge.
REQ-019 RESP: psel=0, penable=0, host_ready=1 for exactly one cycle; return to IDLE unconditionally (host_valid not sampled in RESP, so a request held one cycle past ready is not reissued).
REQ-020 paddr, pwrite, pwdata, pstrb stable from SETUP through ACCESS; apb outputs hold last values in IDLE/RESP.
REQ-021 pslverr=1 on a read completion: host_rdata = 32'hFFFF_FFFF; on write: ignored; transfer still completes normally.
REQ-022 host_rdata unchanged by writes; holds last read value until next read completes.
REQ-023 Latency with zero-wait slave: valid sampled at edge 0 -> host_ready high in cycle 3; each wait state adds one cycle.
REQ-024 host_wdata/host_addr changes after IDLE capture do not affect the in-flight transfer.

Reset
REQ-025 rst=1 asynchronously forces IDLE; host_ready=0, host_rdata=0, apb_psel=0, apb_penable=0, apb_pwrite=0, apb_paddr=0, apb_pwdata=0, apb_pstrb=0, timeout counter=0.
REQ-026 Reset mid-transfer aborts it with no host_ready pulse; after release, a still-high host_valid starts a fresh transfer.

Configuration
REQ-027 Macro APB_BRIDGE_TIMEOUT_EN defined: counter in ACCESS; if pready stays 0 for TIMEOUT_CYCLES cycles, go to RESP, drop psel/penable, reads return 32'hFFFF_FFFF.
REQ-028 Macro undefined: no counter; ACCESS waits indefinitely for pready.

Structure
REQ-029 Package apb_bridge_pkg: state enum typedef, APB_ADDR_W=16, ERR_RDATA=32'hFFFF_FFFF.
REQ-030 Single flat module; no sub-module (FSM plus capture registers only).

Verification
REQ-031 Write addr 0x1000_4000 data 0xAABB_CCDD wstrb 0xF -> SETUP paddr=0x4000, pwrite=1, pstrb=0xF, pwdata=0xAABB_CCDD; one host_ready pulse.
REQ-032 Read 0x1000_4000, slave returns {16'h0,paddr} with one wait state -> host_rdata=0x0000_4000, pstrb=0.
REQ-033 Five back-to-back write/read pairs at 0x1000_5000+4*i, data 0xA000_0000+i -> reads return 0x0000_5000+4*i; no duplicate APB transfers while host_valid is held through RESP.
REQ-034 Read with pslverr=1 -> host_rdata=0xFFFF_FFFF; write with pslverr=1 completes normally.
REQ-035 rst asserted during ACCESS -> psel/penable/host_ready low immediately; next request runs cleanly.
REQ-036 With APB_BRIDGE_TIMEOUT_EN and pready tied 0 -> host_ready after 256 ACCESS cycles, read data 0xFFFF_FFFF.
